// File: rtl/integrate_dump.sv
// integrate_dump: integrate-and-dump of DUMP_LEN samples per symbol, scaled by >>> SHIFT.
// Define INTEGRATE_DUMP_SATURATE_EN to clamp the narrowed output instead of wrapping it.
module integrate_dump #(
  parameter int DATA_W   = 25,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 24,
  parameter int DUMP_LEN = 16,
  parameter int SHIFT    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_valid,
  input  logic signed [DATA_W-1:0]        i_data,
  output logic                            o_ready,
  input  logic                            i_dump_clr,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic signed [OUT_W-1:0]         o_sym,
  output logic                            o_sat,
  output logic [$clog2(DUMP_LEN)-1:0]     o_count
);
  localparam int CNT_W = $clog2(DUMP_LEN);
  logic signed [ACC_W-1:0] acc, sample, sum, shifted;
  logic signed [OUT_W-1:0] narrow;
  logic last, accept, sat;
  assign last    = o_count == CNT_W'(DUMP_LEN - 1);
  assign o_ready = !(last && o_valid && !i_ready);
  assign accept  = i_valid && o_ready;
  assign sample  = {{(ACC_W-DATA_W){i_data[DATA_W-1]}}, i_data};
  assign sum     = acc + sample;
  assign shifted = sum >>> SHIFT;
`ifdef INTEGRATE_DUMP_SATURATE_EN
  // In range only when every bit above the output sign bit matches it.
  logic [ACC_W-OUT_W:0] top;
  assign top    = shifted[ACC_W-1:OUT_W-1];
  assign sat    = !(&top || ~|top);
  assign narrow = !sat ? shifted[OUT_W-1:0] :
                  shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`else
  assign sat    = 1'b0;
  assign narrow = OUT_W'(shifted);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_sym   <= '0;
      o_sat   <= 1'b0;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (accept && i_dump_clr) begin
        acc     <= sample;
        o_count <= CNT_W'(1);
      end else if (accept && last) begin
        acc     <= '0;
        o_count <= '0;
        o_sym   <= narrow;
        o_sat   <= sat;
        o_valid <= 1'b1;
      end else if (accept) begin
        acc     <= sum;
        o_count <= o_count + CNT_W'(1);
      end else if (i_dump_clr) begin
        acc     <= '0;
        o_count <= '0;
      end
    end
  end
endmodule

// File: doc/integrate_dump.md
INTEGRATE_DUMP -- requirements
Module: integrate_dump

Interface
REQ-001 The block SHALL have parameter DATA_W, default 25, giving the signed input sample width (the adder-stage sum width).
REQ-002 The block SHALL have parameter ACC_W, default 32, giving the signed accumulator width; ACC_W >= DATA_W + clog2(DUMP_LEN).
REQ-003 The block SHALL have parameter OUT_W, default 24, giving the signed output width.
REQ-004 The block SHALL have parameter DUMP_LEN, default 16, giving the number of samples per symbol (range 2..1024).
REQ-005 The block SHALL have parameter SHIFT, default 4, giving the arithmetic right shift applied to the dumped sum (range 0..ACC_W-1).
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 i_valid  input  1  upstream sample valid.
REQ-009 i_data  input  DATA_W  signed upstream sample.
REQ-010 o_ready  output  1  block can accept a sample this cycle.
REQ-011 i_dump_clr  input  1  symbol-timing realign: discard the partial symbol.
REQ-012 o_valid  output  1  o_sym holds a completed symbol.
REQ-013 i_ready  input  1  downstream consumer accepts o_sym.
REQ-014 o_sym  output  OUT_W  signed scaled symbol sum.
REQ-015 o_sat  output  1  o_sym was saturated; qualified by o_valid.
REQ-016 o_count  output  clog2(DUMP_LEN)  samples accumulated in the current symbol.

Function
REQ-017 A sample SHALL be accepted when i_valid && o_ready is high on a rising edge.
REQ-018 Sign-extended accepted samples SHALL be added to the ACC_W accumulator, and o_count SHALL increment for each accepted sample.
REQ-019 On accepting the DUMP_LEN-th sample, the block SHALL load o_sym with (acc + sample) >>> SHIFT narrowed to OUT_W, set o_valid, and clear acc and o_count to 0, all on the same edge (latency 1 cycle).
REQ-020 o_valid and o_sym SHALL be held stable until a cycle with o_valid && i_ready; o_valid SHALL then clear unless a new symbol completes on that same edge.
REQ-021 o_ready SHALL be high except when o_count == DUMP_LEN-1 && o_valid && !i_ready; samples that do not complete a symbol are accepted while output is stalled.
REQ-022 o_ready SHALL be combinational from o_count, o_valid and i_ready only, with no dependence on i_valid.
REQ-023 When i_dump_clr is high and no sample is accepted, acc and o_count SHALL clear to 0 on the edge; a pending o_sym/o_valid SHALL NOT be affected.
REQ-024 When i_dump_clr is high and a sample is accepted on the same edge, the sample SHALL start a new symbol (acc = sample, o_count = 1).
REQ-025 With i_dump_clr high and DUMP_LEN samples pending, no symbol SHALL be emitted by the clear itself.
REQ-026 The shift SHALL be arithmetic, truncating toward negative infinity, with no rounding.

Reset
REQ-027 While reset is high on an edge: acc = 0, o_count = 0, o_valid = 0, o_sym = 0, o_sat = 0; reset SHALL override all other inputs.
REQ-028 Reset mid-symbol SHALL discard the partial sum, and the first accepted sample after reset SHALL be sample 1 of a new symbol.

Configuration
REQ-029 With INTEGRATE_DUMP_SATURATE_EN defined, narrowing SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and o_sat SHALL be set with o_sym when clamping occurred.
REQ-030 Without INTEGRATE_DUMP_SATURATE_EN, narrowing SHALL keep the low OUT_W bits (two's-complement wrap), and o_sat SHALL be constant 0.

Verification
REQ-031 Test 1: DUMP_LEN=4, SHIFT=0, i_ready=1; samples 1, 2, 3, 4 back-to-back -> o_valid one cycle after the 4th sample, o_sym = 10; o_count back to 0.
REQ-032 Test 2: DUMP_LEN=4, SHIFT=2; samples -5, -5, -5, -6 -> o_sym = -6 (-21 >>> 2).
REQ-033 Test 3: DUMP_LEN=4, i_ready=0 after the first symbol completes; 3 further samples are accepted, o_ready drops at o_count = 3, and o_sym stays constant; raising i_ready -> first symbol consumed, 4th sample accepted, second symbol valid on the next cycle.
REQ-034 Test 4: i_dump_clr with a sample after 2 samples (7, 7), then samples 1, 1, 1 -> o_sym = 4 (3 + 1), not 17.
REQ-035 Test 5: OUT_W=8, SHIFT=0, DUMP_LEN=4; samples 100 x4 -> with INTEGRATE_DUMP_SATURATE_EN: o_sym = 127, o_sat = 1; without it: o_sym = -112, o_sat = 0.
REQ-036 Test 6: reset asserted for one cycle after 3 samples, then 4 samples of 1 -> o_sym = 4, with no output emitted before that.
